// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : configure (package)
//  Purpose  : Op encodings, FSM state type and op legality helper for the LSU.
//  Revision : 1.0 - initial release
// ============================================================================
package configure;

    localparam logic [2:0] lsu_lb  = 3'b000;
    localparam logic [2:0] lsu_lh  = 3'b001;
    localparam logic [2:0] lsu_lw  = 3'b010;
    localparam logic [2:0] lsu_lbu = 3'b100;
    localparam logic [2:0] lsu_lhu = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == lsu_lb) || (op == lsu_lh) || (op == lsu_lw) ||
               (op == lsu_lbu) || (op == lsu_lhu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Store strobe/lane replication and load lane extraction/extension.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_align (
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            2'b00: begin
                st_wstrb = 4'b0001 << st_lane;
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_wstrb = 4'b0011 << {st_lane[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_word[7:0];
        case (ld_lane)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    end

    // op[2] selects zero extension (lbu/lhu), otherwise sign extension
    always_comb begin
        ld_data = ld_word;
        case (ld_op[1:0])
            2'b00:   ld_data = ld_op[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = ld_op[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Single-outstanding load/store unit with alignment, fault and
//             timeout handling; all outputs registered.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu
    import configure::*;
#(
    parameter int unsigned timeout_limit = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        lsu_load,
    input  logic        lsu_store,
    input  logic [2:0]  lsu_op,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_ready,
    output logic        lsu_misalign,
    output logic        lsu_error,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [8:0] limit = 9'(timeout_limit);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic        load_q;

    logic        one_kind, any_kind, illegal, misaligned, accept, done, timeout;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata, ld_data;

    logic        mem_valid_nx, lsu_ready_nx, lsu_misalign_nx, lsu_error_nx;
    logic [31:0] lsu_rdata_nx, mem_addr_nx, mem_wdata_nx;
    logic [3:0]  mem_wstrb_nx;

    assign mem_instr = 1'b0;

    assign one_kind   = lsu_load ^ lsu_store;
    assign any_kind   = lsu_load | lsu_store;
    assign illegal    = lsu_valid && any_kind &&
                        ((lsu_load && lsu_store) || !op_legal(lsu_op) || (lsu_store && lsu_op[2]));
    assign misaligned = lsu_valid && one_kind && !illegal &&
                        (((lsu_op[1:0] == 2'b01) && lsu_addr[0]) ||
                         ((lsu_op[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00)));
    assign accept     = lsu_valid && one_kind && !illegal && !misaligned;
    assign done       = (state == BUSY) && mem_ready;
    // Ready in the same cycle the limit is reached wins over the timeout
    assign timeout    = (state == BUSY) && !mem_ready && (({1'b0, cnt} + 9'd1) == limit);

    lsu_align u_align (
        .st_size  (lsu_op[1:0]),
        .st_lane  (lsu_addr[1:0]),
        .st_data  (lsu_wdata),
        .st_wstrb (st_wstrb),
        .st_wdata (st_wdata),
        .ld_op    (op_q),
        .ld_lane  (lane_q),
        .ld_word  (mem_rdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = BUSY;
            BUSY:    if (done || timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_valid_nx    = mem_valid;
        mem_addr_nx     = mem_addr;
        mem_wdata_nx    = mem_wdata;
        mem_wstrb_nx    = mem_wstrb;
        lsu_ready_nx    = 1'b0;
        lsu_misalign_nx = 1'b0;
        lsu_error_nx    = 1'b0;
        lsu_rdata_nx    = 32'd0;
        cnt_nx          = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    mem_valid_nx = 1'b1;
                    mem_addr_nx  = {lsu_addr[31:2], 2'b00};
                    mem_wdata_nx = st_wdata;
                    mem_wstrb_nx = lsu_store ? st_wstrb : 4'b0000;
                    cnt_nx       = 8'd0;
                end else if (misaligned) begin
                    lsu_ready_nx    = 1'b1;
                    lsu_misalign_nx = 1'b1;
                end else if (illegal) begin
                    lsu_ready_nx = 1'b1;
                    lsu_error_nx = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    mem_valid_nx = 1'b0;
                    lsu_ready_nx = 1'b1;
                    lsu_rdata_nx = load_q ? ld_data : 32'd0;
                end else if (timeout) begin
                    mem_valid_nx = 1'b0;
                    lsu_ready_nx = 1'b1;
                    lsu_error_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: mem_valid_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid    <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_wstrb    <= 4'd0;
            lsu_ready    <= 1'b0;
            lsu_misalign <= 1'b0;
            lsu_error    <= 1'b0;
            lsu_rdata    <= 32'd0;
            cnt          <= 8'd0;
            op_q         <= 3'd0;
            lane_q       <= 2'd0;
            load_q       <= 1'b0;
        end else begin
            mem_valid    <= mem_valid_nx;
            mem_addr     <= mem_addr_nx;
            mem_wdata    <= mem_wdata_nx;
            mem_wstrb    <= mem_wstrb_nx;
            lsu_ready    <= lsu_ready_nx;
            lsu_misalign <= lsu_misalign_nx;
            lsu_error    <= lsu_error_nx;
            lsu_rdata    <= lsu_rdata_nx;
            cnt          <= cnt_nx;
            if (state == IDLE && accept) begin
                op_q   <= lsu_op;
                lane_q <= lsu_addr[1:0];
                load_q <= lsu_load;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu
//  Purpose  : Scoreboard bench for the LSU (timeout_limit = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lsu_valid = 1'b0, lsu_load = 1'b0, lsu_store = 1'b0;
    logic [2:0]  lsu_op = 3'd0;
    logic [31:0] lsu_addr = 32'd0, lsu_wdata = 32'd0;
    logic [31:0] lsu_rdata;
    logic        lsu_ready, lsu_misalign, lsu_error;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;

    typedef struct packed {
        logic        mis;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    lsu #(.timeout_limit(4)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid(lsu_valid), .lsu_load(lsu_load), .lsu_store(lsu_store),
        .lsu_op(lsu_op), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_rdata(lsu_rdata), .lsu_ready(lsu_ready),
        .lsu_misalign(lsu_misalign), .lsu_error(lsu_error),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Entered at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic ld, input logic st, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
        lsu_valid = 1'b1; lsu_load = ld; lsu_store = st;
        lsu_op = op; lsu_addr = addr; lsu_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        lsu_valid = 1'b0; lsu_load = 1'b0; lsu_store = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (lsu_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({mem_valid, mem_wstrb, lsu_ready, lsu_misalign, lsu_error, mem_instr} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0", {mem_valid, mem_wstrb, lsu_ready, lsu_misalign, lsu_error, mem_instr});
        end
        vectors++;
        if ({lsu_rdata, mem_addr, mem_wdata} !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", {lsu_rdata, mem_addr, mem_wdata});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_word;
        bit ok;
        exp_t e;
        sb.push_back('{mis: 1'b0, err: 1'b0, rdata: 32'd0});
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        vectors++;
        if ({mem_valid, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, 4'b1111, 32'h100, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL sw_req: got v=%b s=%b a=%h d=%h want v=1 s=1111 a=00000100 d=deadbeef",
                     mem_valid, mem_wstrb, mem_addr, mem_wdata);
        end
        @(negedge clk);
        vectors++;
        if ({mem_valid, lsu_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL sw_hold: got valid/ready=%b want 10", {mem_valid, lsu_ready});
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        wait_ready(4, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL sw_done: got no lsu_ready want lsu_ready");
        end else begin
            e = sb.pop_front();
            if ({lsu_misalign, lsu_error, lsu_rdata, mem_valid} !== {e.mis, e.err, e.rdata, 1'b0}) begin
                miscompares++;
                $display("FAIL sw_done: got m=%b e=%b r=%h v=%b want m=%b e=%b r=%h v=0",
                         lsu_misalign, lsu_error, lsu_rdata, mem_valid, e.mis, e.err, e.rdata);
            end
        end
        @(negedge clk);
        vectors++;
        if ({lsu_ready, mem_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL sw_pulse: got ready/valid=%b want 00", {lsu_ready, mem_valid});
        end
    endtask

    task automatic test_store_sub;
        logic [31:0] addrs [2] = '{32'h0000_0102, 32'h0000_0101};
        logic [2:0]  ops   [2] = '{3'b001, 3'b000};
        logic [31:0] wds   [2] = '{32'h0000_1234, 32'h0000_00AB};
        logic [3:0]  strbs [2] = '{4'b1100, 4'b0010};
        logic [31:0] reps  [2] = '{32'h1234_1234, 32'hABAB_ABAB};
        bit ok;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{mis: 1'b0, err: 1'b0, rdata: 32'd0});
            issue(1'b0, 1'b1, ops[i], addrs[i], wds[i]);
            vectors++;
            if ({mem_valid, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, strbs[i], 32'h100, reps[i]}) begin
                miscompares++;
                $display("FAIL st_sub%0d: got v=%b s=%b a=%h d=%h want v=1 s=%b a=00000100 d=%h",
                         i, mem_valid, mem_wstrb, mem_addr, mem_wdata, strbs[i], reps[i]);
            end
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            wait_ready(4, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL st_sub%0d_done: got no lsu_ready want lsu_ready", i);
            end else begin
                e = sb.pop_front();
                if ({lsu_misalign, lsu_error, lsu_rdata} !== {e.mis, e.err, e.rdata}) begin
                    miscompares++;
                    $display("FAIL st_sub%0d_done: got r=%h want r=%h", i, lsu_rdata, e.rdata);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  ops   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b000};
        logic [31:0] addrs [7] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h104, 32'h100, 32'h101};
        logic [31:0] words [7] = '{32'h80FF_FF7F, 32'h80FF_FF7F, 32'h80FF_FF7F, 32'h80FF_FF7F,
                                   32'h1234_5678, 32'h80FF_FF7F, 32'h80FF_FF7F};
        logic [31:0] exps  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_FF7F,
                                   32'h1234_5678, 32'h0000_007F, 32'hFFFF_FFFF};
        bit ok;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{mis: 1'b0, err: 1'b0, rdata: exps[i]});
            issue(1'b1, 1'b0, ops[i], addrs[i], 32'hFFFF_FFFF);
            vectors++;
            if ({mem_valid, mem_wstrb, mem_addr} !== {1'b1, 4'b0000, addrs[i] & 32'hFFFF_FFFC}) begin
                miscompares++;
                $display("FAIL ld%0d_req: got v=%b s=%b a=%h want v=1 s=0000 a=%h",
                         i, mem_valid, mem_wstrb, mem_addr, addrs[i] & 32'hFFFF_FFFC);
            end
            mem_rdata = words[i];
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = 32'h5A5A_5A5A;
            wait_ready(4, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL ld%0d_done: got no lsu_ready want lsu_ready", i);
            end else begin
                e = sb.pop_front();
                if ({lsu_misalign, lsu_error, lsu_rdata} !== {e.mis, e.err, e.rdata}) begin
                    miscompares++;
                    $display("FAIL ld%0d_data: got m=%b e=%b r=%h want m=%b e=%b r=%h",
                             i, lsu_misalign, lsu_error, lsu_rdata, e.mis, e.err, e.rdata);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_faults;
        logic       lds [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       sts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0] ops [5] = '{3'b010, 3'b011, 3'b010, 3'b100, 3'b001};
        logic [31:0] ads[5] = '{32'h101, 32'h100, 32'h100, 32'h100, 32'h103};
        logic       mis [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{mis: mis[i], err: !mis[i], rdata: 32'd0});
            issue(lds[i], sts[i], ops[i], ads[i], 32'h1111_2222);
            vectors++;
            if (lsu_ready !== 1'b1 || mem_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL fault%0d_resp: got ready=%b valid=%b want ready=1 valid=0", i, lsu_ready, mem_valid);
            end else begin
                e = sb.pop_front();
                if ({lsu_misalign, lsu_error, lsu_rdata} !== {e.mis, e.err, e.rdata}) begin
                    miscompares++;
                    $display("FAIL fault%0d_kind: got m=%b e=%b r=%h want m=%b e=%b r=%h",
                             i, lsu_misalign, lsu_error, lsu_rdata, e.mis, e.err, e.rdata);
                end
            end
            @(negedge clk);
            vectors++;
            if ({lsu_ready, lsu_misalign, lsu_error, mem_valid} !== 4'b0000) begin
                miscompares++;
                $display("FAIL fault%0d_pulse: got %b want 0000", i, {lsu_ready, lsu_misalign, lsu_error, mem_valid});
            end
        end
        issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
        vectors++;
        if ({lsu_ready, mem_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL no_kind: got ready/valid=%b want 00", {lsu_ready, mem_valid});
        end
    endtask

    task automatic test_timeout;
        int   seen;
        exp_t e;
        sb.push_back('{mis: 1'b0, err: 1'b1, rdata: 32'd0});
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
        seen = 0;
        while (mem_valid === 1'b1 && seen < 10) begin
            seen++;
            @(negedge clk);
        end
        vectors++;
        if (seen != 4) begin
            miscompares++;
            $display("FAIL to_len: got %0d busy cycles want 4", seen);
        end
        vectors++;
        if (lsu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL to_ready: got lsu_ready=%b want 1", lsu_ready);
        end else begin
            e = sb.pop_front();
            if ({lsu_misalign, lsu_error, lsu_rdata} !== {e.mis, e.err, e.rdata}) begin
                miscompares++;
                $display("FAIL to_kind: got m=%b e=%b r=%h want m=0 e=1 r=0", lsu_misalign, lsu_error, lsu_rdata);
            end
        end
        @(negedge clk);
        sb.push_back('{mis: 1'b0, err: 1'b0, rdata: 32'h0BAD_F00D});
        issue(1'b1, 1'b0, 3'b010, 32'h204, 32'h0);
        repeat (3) @(negedge clk);
        vectors++;
        if (mem_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL edge_valid: got mem_valid=%b want 1", mem_valid);
        end
        mem_rdata = 32'h0BAD_F00D;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        vectors++;
        if (lsu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL edge_ready: got lsu_ready=%b want 1", lsu_ready);
        end else begin
            e = sb.pop_front();
            if ({lsu_misalign, lsu_error, lsu_rdata} !== {e.mis, e.err, e.rdata}) begin
                miscompares++;
                $display("FAIL edge_kind: got m=%b e=%b r=%h want m=0 e=0 r=%h",
                         lsu_misalign, lsu_error, lsu_rdata, e.rdata);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_busy;
        bit   ok;
        exp_t e;
        issue(1'b0, 1'b1, 3'b010, 32'h300, 32'hFEED_FACE);
        vectors++;
        if (mem_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rb_busy: got mem_valid=%b want 1", mem_valid);
        end
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({mem_valid, mem_wstrb, lsu_ready, mem_addr, mem_wdata} !== 70'd0) begin
            miscompares++;
            $display("FAIL rb_async: got v=%b s=%b r=%b a=%h d=%h want all 0",
                     mem_valid, mem_wstrb, lsu_ready, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({lsu_ready, mem_valid} !== 2'b00) begin
                miscompares++;
                $display("FAIL rb_quiet%0d: got ready/valid=%b want 00", i, {lsu_ready, mem_valid});
            end
        end
        mem_ready = 1'b0;
        sb.push_back('{mis: 1'b0, err: 1'b0, rdata: 32'hFFFF_8001});
        issue(1'b1, 1'b0, 3'b001, 32'h302, 32'h0);
        mem_rdata = 32'h8001_0000;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        wait_ready(4, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rb_next: got no lsu_ready want lsu_ready");
        end else begin
            e = sb.pop_front();
            if ({lsu_misalign, lsu_error, lsu_rdata} !== {e.mis, e.err, e.rdata}) begin
                miscompares++;
                $display("FAIL rb_next: got r=%h want r=%h", lsu_rdata, e.rdata);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit   ok;
        exp_t e;
        sb.push_back('{mis: 1'b0, err: 1'b0, rdata: 32'hCAFE_F00D});
        sb.push_back('{mis: 1'b0, err: 1'b0, rdata: 32'h0000_00F0});
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        mem_rdata = 32'hCAFE_F00D;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        wait_ready(4, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_first: got no lsu_ready want lsu_ready");
        end else begin
            e = sb.pop_front();
            if (lsu_rdata !== e.rdata) begin
                miscompares++;
                $display("FAIL b2b_first: got r=%h want r=%h", lsu_rdata, e.rdata);
            end
        end
        issue(1'b1, 1'b0, 3'b100, 32'h401, 32'h0);
        vectors++;
        if ({mem_valid, mem_addr} !== {1'b1, 32'h400}) begin
            miscompares++;
            $display("FAIL b2b_accept: got v=%b a=%h want v=1 a=00000400", mem_valid, mem_addr);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        wait_ready(4, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_second: got no lsu_ready want lsu_ready");
        end else begin
            e = sb.pop_front();
            if (lsu_rdata !== e.rdata) begin
                miscompares++;
                $display("FAIL b2b_second: got r=%h want r=%h", lsu_rdata, e.rdata);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_sub();
        test_loads();
        test_faults();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: timeout_limit, default 255, max cycles waited for mem_ready before an access is aborted (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 lsu_valid  input  1  core request strobe, sampled only in IDLE.
REQ-005 lsu_load  input  1  request is a load.
REQ-006 lsu_store  input  1  request is a store.
REQ-007 lsu_op  input  3  size/sign code: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; others reserved.
REQ-008 lsu_addr  input  32  byte address.
REQ-009 lsu_wdata  input  32  store data, right-aligned.
REQ-010 lsu_rdata  output  32  load result, extended to 32 bits; valid only while lsu_ready=1.
REQ-011 lsu_ready  output  1  one-cycle completion pulse.
REQ-012 lsu_misalign  output  1  completion carries a misaligned-address fault.
REQ-013 lsu_error  output  1  completion carries an illegal-request or timeout fault.
REQ-014 mem_valid  output  1  memory request, held high until mem_ready or timeout.
REQ-015 mem_instr  output  1  constant 0 (data access).
REQ-016 mem_addr  output  32  word address {lsu_addr[31:2],2'b00}.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_wstrb  output  4  byte strobes; 0000 for loads.
REQ-019 mem_rdata  input  32  memory read word.
REQ-020 mem_ready  input  1  memory completion, sampled only while mem_valid=1.

Function
REQ-021 States: IDLE and BUSY; all outputs are registered.
REQ-022 IDLE with lsu_valid=1, exactly one of load/store, legal op, aligned address: the block goes to BUSY and drives mem_valid=1 with stable addr/wdata/wstrb from the next cycle (cycle N+1).
REQ-023 Alignment: lh/lhu/sh need addr[0]=0; lw/sw need addr[1:0]=00; byte accesses are always aligned.
REQ-024 Misaligned request: no memory access; at N+1 lsu_ready=1, lsu_misalign=1, lsu_rdata=0; remains IDLE.
REQ-025 Reserved op, load and store both set, or store with op 100/101: no memory access; at N+1 lsu_ready=1, lsu_error=1, lsu_rdata=0.
REQ-026 lsu_valid with neither load nor store is ignored; lsu_valid outside IDLE is ignored.
REQ-027 Store strobes: sb = 0001<<addr[1:0]; sh = 0011<<{addr[1],1'b0}; sw = 1111.
REQ-028 Store data: byte is replicated 4x, half is replicated 2x, word is passed through.
REQ-029 BUSY, mem_ready=1 in cycle M: at M+1 mem_valid=0, lsu_ready=1, state IDLE; a new lsu_valid in M+1 is accepted.
REQ-030 Load result: the byte/half at lane addr[1:0] is taken from mem_rdata captured at M, sign-extended (lb/lh) or zero-extended (lbu/lhu); lw returns the word unchanged.
REQ-031 Store completion: lsu_rdata=0.
REQ-032 Timeout counter clears on entry to BUSY and increments each BUSY cycle without mem_ready; when it reaches timeout_limit the block drops mem_valid next cycle, pulses lsu_ready with lsu_error=1, and returns to IDLE.
REQ-033 mem_ready in the same cycle the counter reaches its limit counts as a normal completion (no error).
REQ-034 lsu_ready, lsu_misalign and lsu_error are single-cycle pulses; misalign and error are never high without lsu_ready.

Reset
REQ-035 rst=0 asynchronously forces IDLE, counter=0, and all outputs to 0 (mem_valid, mem_wstrb, lsu_ready, lsu_misalign, lsu_error, rdata, addr, wdata).
REQ-036 Reset during BUSY abandons the access with no completion pulse after release; the first cycle after release is IDLE.

Structure
REQ-037 Op encodings (lsu_lb..lsu_lhu) and the IDLE/BUSY state typedef live in package configure.
REQ-038 One combinational sub-module, lsu_align, performs strobe/replication generation and load lane extraction/extension; lsu holds the FSM, registers and counter.

Verification
REQ-039 sw 0x100, wdata 0xDEADBEEF, ready after 2 cycles -> mem_wstrb=1111, mem_addr=0x100, one lsu_ready pulse, rdata 0.
REQ-040 lb 0x103, mem_rdata 0x80FF_FF7F -> lsu_rdata 0xFFFF_FF80; lbu 0x103 -> 0x0000_0080.
REQ-041 sh 0x102, wdata 0x1234 -> mem_wstrb=1100, mem_wdata=0x1234_1234, mem_addr=0x100.
REQ-042 lw 0x101 -> no mem_valid; lsu_ready+lsu_misalign next cycle; op 011 -> lsu_ready+lsu_error.
REQ-043 timeout_limit=4, mem_ready held low -> mem_valid drops and lsu_error pulses after 4 BUSY cycles; same run with mem_ready on the 4th cycle -> normal completion.
REQ-044 rst asserted mid-BUSY -> outputs 0 immediately; no lsu_ready after release; next request completes normally.
